rgb2ycbcr: RTL and testbench

RGB2YCBCR -- requirements
Module: rgb2ycbcr

---
 rtl/rgb2ycbcr_pkg.sv | 34 +++
 rtl/datapath.vh | 29 ++
 rtl/rgb2ycbcr_chan.sv | 59 +++++
 rtl/rgb2ycbcr.sv | 78 +++++++
 tb/tb_rgb2ycbcr.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb2ycbcr_pkg.sv
// Shared types and helpers for the rgb2ycbcr converter.
//   pix_t  : one 8-bit unsigned colour component
//   sum_t  : signed product/sum word
//   tag_t  : per-stage valid/last sideband carried alongside the data
//   sat_u8 : clamp a signed sum to 0..255
`include "datapath.vh"

package rgb2ycbcr_pkg;

  localparam int PIX_W = `DP_PIX_W;
  localparam int SUM_W = `DP_SUM_W;
  localparam int SHIFT = `DP_SHIFT;

  typedef logic [PIX_W-1:0]        pix_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam sum_t PIX_MAX = sum_t'((1 << PIX_W) - 1);

  function automatic pix_t sat_u8(input sum_t v);
    if (v < 0) begin
      return '0;
    end else if (v > PIX_MAX) begin
      return '1;
    end else begin
      return v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/datapath.vh
// Datapath constants for the RGB -> YCbCr (BT.601 studio range) converter.
// Coefficients are scaled by 256. The sum width is large enough for every
// product and partial sum, so nothing overflows before the final shift.
`ifndef DATAPATH_VH
`define DATAPATH_VH

`define DP_PIX_W   8
`define DP_SUM_W   18
`define DP_SHIFT   8

// Y row
`define DP_Y_KR    66
`define DP_Y_KG    129
`define DP_Y_KB    25
// Cb row
`define DP_CB_KR   (-38)
`define DP_CB_KG   (-74)
`define DP_CB_KB   112
// Cr row
`define DP_CR_KR   112
`define DP_CR_KG   (-94)
`define DP_CR_KB   (-18)

// Output offsets and rounding constant (half of 2^DP_SHIFT)
`define DP_Y_OFF   16
`define DP_C_OFF   128
`define DP_RC      128

`endif

// File: rtl/rgb2ycbcr_chan.sv
// One output channel of the colour converter: c = sat((kr*r + kg*g + kb*b + rc) >>> 8) + offset).
// Three data stages; the top owns valid/last tracking and drives en.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (clears all data registers)
//   en      : pipeline advance enable, shared by all channels
//   r, g, b : unsigned input components
//   c       : saturated 8-bit channel result (stage-3 register)
`include "datapath.vh"

module rgb2ycbcr_chan
  import rgb2ycbcr_pkg::*;
#(
  parameter int KR     = 0,
  parameter int KG     = 0,
  parameter int KB     = 0,
  parameter int OFFSET = 0,
  parameter int RC     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t r,
  input  pix_t g,
  input  pix_t b,
  output pix_t c
);

  localparam sum_t KR_S  = sum_t'(KR);
  localparam sum_t KG_S  = sum_t'(KG);
  localparam sum_t KB_S  = sum_t'(KB);
  localparam sum_t OFF_S = sum_t'(OFFSET);
  localparam sum_t RC_S  = sum_t'(RC);

  sum_t prod_r;
  sum_t prod_g;
  sum_t prod_b;
  sum_t sum_s2;

  // Components are zero-extended before the signed multiply so that an
  // input of 255 is never read as -1.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      sum_s2 <= '0;
      c      <= '0;
    end else if (en) begin
      prod_r <= sum_t'(r) * KR_S;
      prod_g <= sum_t'(g) * KG_S;
      prod_b <= sum_t'(b) * KB_S;
      sum_s2 <= prod_r + prod_g + prod_b + RC_S;
      // Arithmetic shift floors negative chroma sums toward minus infinity.
      c      <= sat_u8((sum_s2 >>> SHIFT) + OFF_S);
    end
  end

endmodule

// File: rtl/rgb2ycbcr.sv
// RGB -> YCbCr (BT.601 studio range) converter with a 3-stage pipeline and
// valid/ready handshakes on both sides. Latency is 3 cycles, 1 pixel/cycle.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : input handshake
//   R, G, B, in_last    : input pixel and end-of-line flag
//   out_valid, out_ready: output handshake
//   Y, Cb, Cr, out_last : converted pixel and its end-of-line flag
// Parameter ROUND: 1 adds the rounding constant before the shift, 0 truncates.
`include "datapath.vh"

module rgb2ycbcr
  import rgb2ycbcr_pkg::*;
#(
  parameter int ROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic       out_last
);

  localparam int RC = (ROUND != 0) ? `DP_RC : 0;

  logic en;
  tag_t tag_s1;
  tag_t tag_s2;
  tag_t tag_s3;

  // The whole pipeline moves as one: it advances whenever the output
  // register is empty or being drained this cycle.
  assign en        = !tag_s3.valid || out_ready;
  // Reset forces ready high even before the output register has cleared.
  assign in_ready  = en || rst;
  assign out_valid = tag_s3.valid;
  assign out_last  = tag_s3.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_s1 <= '0;
      tag_s2 <= '0;
      tag_s3 <= '0;
    end else if (en) begin
      tag_s1 <= '{valid: in_valid, last: in_valid & in_last};
      tag_s2 <= tag_s1;
      tag_s3 <= tag_s2;
    end
  end

  rgb2ycbcr_chan #(
    .KR(`DP_Y_KR), .KG(`DP_Y_KG), .KB(`DP_Y_KB), .OFFSET(`DP_Y_OFF), .RC(RC)
  ) u_chan_y (
    .clk(clk), .rst(rst), .en(en), .r(R), .g(G), .b(B), .c(Y)
  );

  rgb2ycbcr_chan #(
    .KR(`DP_CB_KR), .KG(`DP_CB_KG), .KB(`DP_CB_KB), .OFFSET(`DP_C_OFF), .RC(RC)
  ) u_chan_cb (
    .clk(clk), .rst(rst), .en(en), .r(R), .g(G), .b(B), .c(Cb)
  );

  rgb2ycbcr_chan #(
    .KR(`DP_CR_KR), .KG(`DP_CR_KG), .KB(`DP_CR_KB), .OFFSET(`DP_C_OFF), .RC(RC)
  ) u_chan_cr (
    .clk(clk), .rst(rst), .en(en), .r(R), .g(G), .b(B), .c(Cr)
  );

endmodule

// File: tb/tb_rgb2ycbcr.sv
// Bench for rgb2ycbcr: a rounding instance and a truncating instance share
// the same stimulus; a negedge monitor scoreboards every output pixel against
// a plain-arithmetic reference model.
module tb_rgb2ycbcr;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;
  logic [7:0] r, g, b;
  logic       in_ready, in_ready_t;
  logic       out_valid, out_last, out_valid_t, out_last_t;
  logic [7:0] y, cb, cr, y_t, cb_t, cr_t;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rgb2ycbcr #(.ROUND(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .R(r), .G(g), .B(b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(y), .Cb(cb), .Cr(cr), .out_last(out_last)
  );

  rgb2ycbcr #(.ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .R(r), .G(g), .B(b), .in_last(in_last),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .Y(y_t), .Cb(cb_t), .Cr(cr_t), .out_last(out_last_t)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [23:0] conv(input int rr, input int gg, input int bb, input bit rnd);
    int rc  = rnd ? 128 : 0;
    int yv  = ((66 * rr + 129 * gg + 25 * bb + rc) >>> 8) + 16;
    int cbv = ((-38 * rr - 74 * gg + 112 * bb + rc) >>> 8) + 128;
    int crv = ((112 * rr - 94 * gg - 18 * bb + rc) >>> 8) + 128;
    return {clamp8(yv), clamp8(cbv), clamp8(crv)};
  endfunction

  typedef struct {
    logic [23:0] rnd;
    logic [23:0] trn;
    logic        last;
  } exp_t;

  exp_t sb[$];

  // ---------------- monitor / scoreboard ----------------
  logic [23:0] held;
  logic        held_last;
  bit          was_stalled = 0;
  int          n_out = 0;
  int          n_last_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      was_stalled = 0;
    end else begin
      if (was_stalled) begin
        chk_eq("stall_hold", 32'({out_valid, out_last, y, cb, cr}), 32'({1'b1, held_last, held}));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        n_out++;
        if (out_last) n_last_out++;
        chk_eq("out_has_expected", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk_eq("pix_round", 32'({y, cb, cr}), 32'(e.rnd));
          chk_eq("pix_trunc", 32'({y_t, cb_t, cr_t}), 32'(e.trn));
          chk_eq("pix_last", 32'(out_last), 32'(e.last));
          chk_eq("trunc_valid", 32'(out_valid_t), 32'(1));
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.rnd  = conv(int'(r), int'(g), int'(b), 1'b1);
        n.trn  = conv(int'(r), int'(g), int'(b), 1'b0);
        n.last = in_last;
        sb.push_back(n);
      end
      was_stalled = out_valid && !out_ready;
      held        = {y, cb, cr};
      held_last   = out_last;
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; holds the pixel until it is accepted.
  task automatic send(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                      input logic lst);
    int k = 0;
    r = rr; g = gg; b = bb; in_last = lst; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk_eq("send_timeout", 32'(k), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_px(input string tag, input int max_wait,
                           input logic [23:0] e_rnd, input logic [23:0] e_trn);
    int k = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && k < max_wait) begin
      @(negedge clk);
      k++;
    end
    chk_eq({tag, "_seen"}, 32'(out_valid && out_ready), 32'(1));
    chk_eq({tag, "_rnd"}, 32'({y, cb, cr}), 32'(e_rnd));
    chk_eq({tag, "_trn"}, 32'({y_t, cb_t, cr_t}), 32'(e_trn));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk_eq(tag, 32'(sb.size()), 32'(0));
    idle(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: time=%0t limit=900000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  bit rand_done = 0;
  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    r = '0; g = '0; b = '0; out_ready = 1'b1;

    @(posedge clk); #1;
    chk_eq("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    chk_eq("rst_outputs", 32'({out_valid, out_last, y, cb, cr}), 32'(0));
    chk_eq("rst_outputs_t", 32'({out_valid_t, out_last_t, y_t, cb_t, cr_t}), 32'(0));
    rst = 1'b0;
    chk_eq("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Black pixel, exact 3-cycle latency.
    r = 8'd0; g = 8'd0; b = 8'd0; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_eq("lat_cycle2", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk_eq("lat_cycle3", 32'(out_valid), 32'(1));
    chk_eq("black", 32'({y, cb, cr}), 32'({8'd16, 8'd128, 8'd128}));
    idle(2);

    // Three primaries back to back.
    send(8'd255, 8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd0,   8'd0,   1'b0);
    send(8'd0,   8'd0,   8'd255, 1'b0);
    expect_px("white", 10, {8'd235, 8'd128, 8'd128}, {8'd235, 8'd128, 8'd128});
    expect_px("red",    0, {8'd82,  8'd90,  8'd240}, {8'd81,  8'd90,  8'd239});
    expect_px("blue",   0, {8'd41,  8'd240, 8'd110}, {8'd40,  8'd239, 8'd110});
    idle(2);

    // Backpressure: 6 pixels offered while out_ready is low for 5 cycles.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_eq("stall_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk_eq("stall_count", 32'(n_out - base), 32'(6));

    // End-of-line flag on the 4th of 4 pixels, random gaps.
    base = n_last_out;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), (i == 3));
      idle($urandom_range(0, 3));
    end
    drain("last_drain");
    chk_eq("last_count", 32'(n_last_out - base), 32'(1));

    // Reset with two pixels in flight.
    send(8'd10, 8'd20, 8'd30, 1'b0);
    send(8'd40, 8'd50, 8'd60, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("midrst_valid", 32'(out_valid), 32'(0));
    chk_eq("midrst_valid_t", 32'(out_valid_t), 32'(0));
    base = n_out;
    idle(8);
    chk_eq("midrst_no_stale", 32'(n_out - base), 32'(0));

    // Random pixels with random gaps and random backpressure.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          send(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("rand_drain");
    chk_eq("rand_count", 32'(n_out - base), 32'(10000));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
